decodificador_hamming: RTL and testbench

// - Receiver stage directly downstream of the bit-error injector. Consumes the 15-bit

---
 rtl/decodificador_hamming_if.sv | 22 ++
 rtl/decodificador_hamming.sv | 122 ++++++++++++
 tb/tb_decodificador_hamming.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decodificador_hamming_if.sv
// Handshake bus of the Hamming(15,11) decoder: codeword in, corrected data out.
// slave = decoder side, master = the producer/consumer side that drives it.
interface decodificador_hamming_if;
    logic [14:0] entrada;
    logic        entrada_valid;
    logic        entrada_ready;
    logic [10:0] saida;
    logic        saida_valid;
    logic        saida_ready;
    logic        corrigido;
    logic [3:0]  sindrome;

    modport master (
        output entrada, entrada_valid, saida_ready,
        input  entrada_ready, saida, saida_valid, corrigido, sindrome
    );

    modport slave (
        input  entrada, entrada_valid, saida_ready,
        output entrada_ready, saida, saida_valid, corrigido, sindrome
    );
endinterface

// File: rtl/decodificador_hamming.sv
// Two-stage Hamming(15,11) single-error-correcting decoder with valid/ready handshake.
// Define HAMMING_CONTADOR_EN to build the saturating corrected-word counter (limpar/cont_corr).
module decodificador_hamming
`ifdef HAMMING_CONTADOR_EN
    #(parameter int CNT_W = 16)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    decodificador_hamming_if.slave bus
`ifdef HAMMING_CONTADOR_EN
    ,
    input  logic                   limpar,
    output logic [CNT_W-1:0]       cont_corr
`endif
);

    // Bit i of the syndrome covers every position whose 1-based index has bit i set.
    function automatic logic [3:0] calc_sindrome(input logic [14:0] w);
        logic [3:0] s;
        logic [3:0] pos;
        s = '0;
        for (int k = 0; k < 15; k++) begin
            pos = 4'(k + 1);
            for (int i = 0; i < 4; i++) begin
                if (pos[i]) s[i] = s[i] ^ w[k];
            end
        end
        return s;
    endfunction

    function automatic logic [14:0] corrigir(input logic [14:0] w, input logic [3:0] s);
        logic [14:0] c;
        c = w;
        if (s != 4'd0) c[4'(s - 4'd1)] = ~c[4'(s - 4'd1)];
        return c;
    endfunction

    function automatic logic [10:0] extrair(input logic [14:0] c);
        return {c[14:8], c[6:4], c[2]};
    endfunction

    logic        stall;
    logic [3:0]  sind_p1_d;
    logic [14:0] cor_p1;
    logic [10:0] saida_p2_d;
    logic        corr_p2_d;

    logic [14:0] ent_p1_q;
    logic [3:0]  sind_p1_q;
    logic        vld_p1_q;
    logic [10:0] saida_p2_q;
    logic        corr_p2_q;
    logic [3:0]  sind_p2_q;
    logic        vld_p2_q;

    // Both stages freeze together, so bubbles are held rather than squeezed out.
    assign stall             = vld_p2_q & ~bus.saida_ready;
    assign bus.entrada_ready = ~stall;

    assign sind_p1_d  = calc_sindrome(bus.entrada);
    assign cor_p1     = corrigir(ent_p1_q, sind_p1_q);
    assign saida_p2_d = extrair(cor_p1);
    assign corr_p2_d  = (sind_p1_q != 4'd0);

    // Stage 1: received word and its syndrome
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_p1_q  <= '0;
            sind_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else if (!stall) begin
            ent_p1_q  <= bus.entrada;
            sind_p1_q <= sind_p1_d;
            vld_p1_q  <= bus.entrada_valid;
        end
    end

    // Stage 2: corrected data out
    always_ff @(posedge clk) begin
        if (rst) begin
            saida_p2_q <= '0;
            corr_p2_q  <= 1'b0;
            sind_p2_q  <= '0;
            vld_p2_q   <= 1'b0;
        end else if (!stall) begin
            saida_p2_q <= saida_p2_d;
            corr_p2_q  <= corr_p2_d;
            sind_p2_q  <= sind_p1_q;
            vld_p2_q   <= vld_p1_q;
        end
    end

    assign bus.saida       = saida_p2_q;
    assign bus.corrigido   = corr_p2_q;
    assign bus.sindrome    = sind_p2_q;
    assign bus.saida_valid = vld_p2_q;

`ifdef HAMMING_CONTADOR_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cont_d;
    logic [CNT_W-1:0] cont_q;

    // limpar wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cont_d = cont_q;
        if (limpar)
            cont_d = '0;
        else if (vld_p2_q && bus.saida_ready && corr_p2_q && cont_q != CNT_MAX)
            cont_d = cont_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cont_q <= '0;
        else     cont_q <= cont_d;
    end

    assign cont_corr = cont_q;
`endif

endmodule

// File: tb/tb_decodificador_hamming.sv
// Randomized bench for decodificador_hamming against a position-arithmetic Hamming model.
// Define HAMMING_CONTADOR_EN to also exercise the corrected-word counter (CNT_W = 2).
module tb_decodificador_hamming;

    typedef struct packed {
        logic [10:0] d;
        logic        c;
        logic [3:0]  s;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic limpar;

    decodificador_hamming_if bus();

`ifdef HAMMING_CONTADOR_EN
    localparam int CNT_W = 2;
    logic [CNT_W-1:0] cont_corr;

    decodificador_hamming #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .limpar    (limpar),
        .cont_corr (cont_corr)
    );
`else
    decodificador_hamming dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_model = 0;
    exp_t sb[$];
    logic stalled_prev = 1'b0;
    logic [10:0] held_saida;
    logic        held_corr;
    logic [3:0]  held_sind;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Data goes to the non-power-of-two positions in ascending order, then
    // each parity position is set so the XOR over its coverage group is zero.
    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] w;
        int j;
        logic p;
        w = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (!is_pow2(pos)) begin
                w[pos-1] = d[j];
                j++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 15; pos++)
                if (((pos >> i) & 1) == 1) p = p ^ w[pos-1];
            w[(1 << i) - 1] = p;
        end
        return w;
    endfunction

    // Syndrome as the XOR of the 1-based indices of every set bit.
    function automatic exp_t ref_decode(input logic [14:0] w_in);
        exp_t e;
        logic [14:0] w;
        int syn;
        int j;
        w = w_in;
        syn = 0;
        for (int pos = 1; pos <= 15; pos++)
            if (w[pos-1]) syn = syn ^ pos;
        if (syn != 0) w[syn-1] = ~w[syn-1];
        e.d = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (!is_pow2(pos)) begin
                e.d[j] = w[pos-1];
                j++;
            end
        end
        e.c = (syn != 0);
        e.s = 4'(syn);
        return e;
    endfunction

    // One cycle: drive at the falling edge, then score what the next rising edge will transfer.
    task automatic step(input logic v, input logic [14:0] w, input logic rdy, input logic lim);
        exp_t e;
        @(negedge clk);
        bus.entrada_valid = v;
        bus.entrada       = w;
        bus.saida_ready   = rdy;
        limpar            = lim;
        #1;
        if (stalled_prev) begin
            chk("hold_valid", 32'(bus.saida_valid), 32'd1);
            chk("hold_saida", 32'(bus.saida), 32'(held_saida));
            chk("hold_corr", 32'(bus.corrigido), 32'(held_corr));
            chk("hold_sind", 32'(bus.sindrome), 32'(held_sind));
        end
        chk("entrada_ready", 32'(bus.entrada_ready), 32'(!(bus.saida_valid && !rdy)));
`ifdef HAMMING_CONTADOR_EN
        chk("cont_corr", 32'(cont_corr), 32'(cnt_model));
`endif
        if (bus.saida_valid && rdy) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(bus.saida_valid), 32'd0);
                e = '0;
            end else begin
                e = sb.pop_front();
                chk("saida", 32'(bus.saida), 32'(e.d));
                chk("corrigido", 32'(bus.corrigido), 32'(e.c));
                chk("sindrome", 32'(bus.sindrome), 32'(e.s));
            end
`ifdef HAMMING_CONTADOR_EN
            if (!lim && e.c && cnt_model < (1 << CNT_W) - 1) cnt_model++;
`endif
        end
`ifdef HAMMING_CONTADOR_EN
        if (lim) cnt_model = 0;
`endif
        if (v && bus.entrada_ready) sb.push_back(ref_decode(w));
        stalled_prev = bus.saida_valid && !rdy;
        held_saida   = bus.saida;
        held_corr    = bus.corrigido;
        held_sind    = bus.sindrome;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst               = 1'b1;
        bus.entrada_valid = 1'b0;
        bus.saida_ready   = 1'b1;
        limpar            = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        cnt_model    = 0;
        stalled_prev = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.saida_valid), 32'd0);
        chk("rst_saida", 32'(bus.saida), 32'd0);
        chk("rst_corr", 32'(bus.corrigido), 32'd0);
        chk("rst_sind", 32'(bus.sindrome), 32'd0);
        chk("rst_ready", 32'(bus.entrada_ready), 32'd1);
`ifdef HAMMING_CONTADOR_EN
        chk("rst_cont", 32'(cont_corr), 32'd0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 15'd0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [14:0] cw;
        logic [14:0] w;
        int fl;

        rst               = 1'b1;
        bus.entrada       = '0;
        bus.entrada_valid = 1'b0;
        bus.saida_ready   = 1'b1;
        limpar            = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Clean word and two-edge latency
        cw = encode(11'h5A3);
        step(1'b1, cw, 1'b1, 1'b0);
        step(1'b0, 15'd0, 1'b1, 1'b0);
        chk("lat_early", 32'(bus.saida_valid), 32'd0);
        step(1'b0, 15'd0, 1'b1, 1'b0);
        chk("lat_valid", 32'(bus.saida_valid), 32'd1);
        chk("clean_saida", 32'(bus.saida), 32'h5A3);
        chk("clean_corr", 32'(bus.corrigido), 32'd0);
        chk("clean_sind", 32'(bus.sindrome), 32'd0);
        drain();

        // Single-error sweep, back to back
        for (int n = 0; n < 15; n++) step(1'b1, cw ^ (15'd1 << n), 1'b1, 1'b0);
        drain();

        // Backpressure: 5 words, consumer stalls on cycles 3..6
        for (int c = 0; c < 10; c++) begin
            w = encode(11'(c * 97 + 5)) ^ (15'd1 << c);
            step(c < 5, w, !(c >= 3 && c <= 6), 1'b0);
        end
        drain();

        // Reset with two words in flight
        step(1'b1, encode(11'h111), 1'b1, 1'b0);
        step(1'b1, encode(11'h222), 1'b1, 1'b0);
        do_reset();
        step(1'b1, encode(11'h2B4) ^ 15'h0400, 1'b1, 1'b0);
        drain();

        // Double error: miscorrection flips position 3
        step(1'b1, cw ^ 15'h0003, 1'b1, 1'b0);
        step(1'b0, 15'd0, 1'b1, 1'b0);
        step(1'b0, 15'd0, 1'b1, 1'b0);
        chk("dbl_sind", 32'(bus.sindrome), 32'd3);
        chk("dbl_corr", 32'(bus.corrigido), 32'd1);
        chk("dbl_saida", 32'(bus.saida), 32'(11'h5A3 ^ 11'h001));
        drain();

`ifdef HAMMING_CONTADOR_EN
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, cw ^ (15'd1 << i), 1'b1, 1'b0);
        drain();
        chk("cont_sat", 32'(cont_corr), 32'd3);
        step(1'b1, cw ^ 15'h0100, 1'b1, 1'b0);
        step(1'b0, 15'd0, 1'b1, 1'b0);
        step(1'b0, 15'd0, 1'b1, 1'b1);
        step(1'b0, 15'd0, 1'b1, 1'b0);
        chk("cont_clear", 32'(cont_corr), 32'd0);
        drain();
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            fl = $urandom_range(0, 15);
            w  = encode(11'($urandom_range(0, 2047)));
            if (fl < 15) w = w ^ (15'd1 << fl);
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
